// File: rtl/uart_tx_buffer_pkg.sv
// Shared types for the UART transmit buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_buffer_pkg;

  localparam int TXB_DATA_WIDTH = 8;

  // Transmit sequencer state: either waiting for data or holding a byte
  // on the core handshake until it is acknowledged.
  typedef enum logic {
    TXB_IDLE = 1'b0,
    TXB_SEND = 1'b1
  } txb_state_t;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Synchronous single-clock FIFO with push/pop/flush and a registered head word.
// Latency: a push into an empty FIFO is visible on head/count one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
// Ports: clk, rst (sync, active-high); push/push_data, pop, flush;
//        head (oldest entry), count, full, empty.
module uart_tx_buffer_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
  logic                  do_push;
  logic                  do_pop;

  // Status comes from the occupancy counter, never from pointer compare.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // full is sampled before any same-cycle pop, so a full FIFO rejects the
  // write even while it is being drained.
  assign do_push    = push & ~full & ~flush;
  assign do_pop     = pop & ~empty & ~flush;
  assign rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head tracks mem[rd_ptr] one cycle ahead. When the word being written
  // lands exactly at the next read slot (empty FIFO, or last word popped
  // while a new one arrives) the RAM still holds stale data, so bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
      head <= push_data;
    end else begin
      head <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue between the bus write strobe and the UART TX core en/data/ack handshake.
// Latency: write into empty FIFO at edge N -> count=1 after N, tx_en/tx_data after N+1.
// Backpressure: writes while full are dropped and set sticky overflow; core paces via tx_ack.
// Ports: clk, rst (sync, active-high); wr_en/wr_data, flush, clr_err from the bus;
//        tx_en/tx_data/tx_busy/tx_ack to the TX core; count/full/empty/idle/overflow status.
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                flush,
  input  logic                clr_err,
  output logic                tx_en,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  input  logic                tx_ack,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                empty,
  output logic                idle,
  output logic                overflow
);

  txb_state_t                state;
  logic [TXB_DATA_WIDTH-1:0] head;
  logic                      pop;
  logic                      drop;

  // Pop whenever the core can take a byte: immediately from IDLE, or on the
  // ack of the current frame so the next one follows with no gap. Flush
  // discards the queue, so nothing is popped in that cycle.
  assign pop  = ~flush & ~empty &
                ((state == TXB_IDLE) | ((state == TXB_SEND) & tx_ack));
  // A write lost to flush is intentional and does not count as overflow.
  assign drop = wr_en & full & ~flush;
  assign idle = empty & (state == TXB_IDLE) & ~tx_busy;

  uart_tx_buffer_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (TXB_DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_err) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TXB_IDLE;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      case (state)
        TXB_IDLE: begin
          if (pop) begin
            tx_data <= head;
            tx_en   <= 1'b1;
            state   <= TXB_SEND;
          end
        end
        TXB_SEND: begin
          if (tx_ack) begin
            if (pop) begin
              tx_data <= head;
            end else begin
              tx_en <= 1'b0;
              state <= TXB_IDLE;
            end
          end
        end
        default: begin
          tx_en <= 1'b0;
          state <= TXB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a stub TX core of programmable ack delay.
// Latency: n/a.
// Backpressure: the stub can hold off tx_ack indefinitely to fill the queue.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_ack = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       idle;
  logic       overflow;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  int         ack_delay = 2;
  bit         hold = 1'b0;
  int         ack_cnt = 0;
  bit         gap;

  always #5 clk = ~clk;

  uart_tx_buffer #(.ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .clr_err  (clr_err),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_ack   (tx_ack),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .idle     (idle),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score a completing frame, advance, then update the stub core.
  task automatic tick();
    logic [7:0] e;
    if (tx_en && tx_ack) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_byte", {24'd0, tx_data}, {24'd0, e});
      end
    end
    @(posedge clk);
    #1;
    if (tx_ack) begin
      tx_ack  = 1'b0;
      ack_cnt = 0;
    end else if (tx_en && !hold) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) tx_ack = 1'b1;
    end
    tx_busy = tx_en;
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, idle}, 32'd1);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // 1: single byte, latency and return to idle
    ack_delay = 2;
    wr(8'hA5, 1'b1);
    check("t1_count_after_write", {27'd0, count}, 32'd1);
    check("t1_tx_en_not_yet", {31'd0, tx_en}, 32'd0);
    tick();
    check("t1_tx_en", {31'd0, tx_en}, 32'd1);
    check("t1_tx_data", {24'd0, tx_data}, 32'hA5);
    check("t1_count_after_pop", {27'd0, count}, 32'd0);
    wait_idle("t1_idle", 50);

    // 2: 16-byte burst, back-to-back frames; pops land on edges 2,4,7,10,13,16
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b1);
    check("t2_count_after_burst", {27'd0, count}, 32'd10);
    check("t2_overflow", {31'd0, overflow}, 32'd0);
    gap = 1'b0;
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      if (!tx_en) gap = 1'b1;
      tick();
    end
    check("t2_no_gap", {31'd0, gap}, 32'd0);
    wait_idle("t2_idle", 50);

    // 3: overflow with ack held; set wins over clr_err
    hold = 1'b1;
    wr(8'h30, 1'b1);
    tick();
    check("t3_in_flight", {31'd0, tx_en}, 32'd1);
    for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i), i < 16);
    check("t3_count", {27'd0, count}, 32'd16);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    clr_err = 1'b1;
    wr(8'h99, 1'b0);
    clr_err = 1'b0;
    check("t3_set_wins", {31'd0, overflow}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t3_clr_err", {31'd0, overflow}, 32'd0);

    // 4: full FIFO, tx_ack and wr_en together -> pop happens, write dropped
    tx_ack  = 1'b1;
    wr(8'hEE, 1'b0);
    check("t4_count", {27'd0, count}, 32'd15);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_tx_en", {31'd0, tx_en}, 32'd1);
    check("t4_tx_data", {24'd0, tx_data}, 32'h40);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    hold = 1'b0;
    ack_delay = 1;
    wait_idle("t4_idle", 100);

    // 5: flush mid-frame with a concurrent write; in-flight byte survives
    hold = 1'b1;
    for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b1);
    check("t5_count_queued", {27'd0, count}, 32'd5);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    check("t5_count_flushed", {27'd0, count}, 32'd0);
    check("t5_empty", {31'd0, empty}, 32'd1);
    check("t5_overflow_unchanged", {31'd0, overflow}, 32'd0);
    tick();
    check("t5_tx_en_held", {31'd0, tx_en}, 32'd1);
    check("t5_tx_data_held", {24'd0, tx_data}, 32'h60);
    hold = 1'b0;
    wait_idle("t5_idle", 50);

    // 6: reset mid-frame with overflow set
    hold = 1'b1;
    for (int i = 0; i < 18; i++) wr(8'h80 + 8'(i), 1'b0);
    check("t6_overflow_before", {31'd0, overflow}, 32'd1);
    check("t6_tx_en_before", {31'd0, tx_en}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_tx_en", {31'd0, tx_en}, 32'd0);
    check("t6_count", {27'd0, count}, 32'd0);
    check("t6_overflow", {31'd0, overflow}, 32'd0);
    check("t6_tx_data", {24'd0, tx_data}, 32'h00);
    exp_q.delete();
    hold = 1'b0;
    ack_cnt = 0;
    tick();
    wr(8'h5A, 1'b1);
    wait_idle("t6_recover_idle", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
